// File: rtl/ddr_line_mover.sv
// Cache-side front end of the DDR controller: arbitrates line fills and evicts,
// issues one burst per line and streams beats between cache and controller.
module ddr_line_mover #(
  parameter int unsigned DDR_DATA_WIDTH = 128,
  parameter int unsigned DDR_ADDR_WIDTH = 28,
  parameter int unsigned LINE_BEATS     = 8,
  parameter int unsigned TIMEOUT        = 4096
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               init_calib_complete,
  input  logic                                               fill_req,
  input  logic [DDR_ADDR_WIDTH-1:0]                          fill_addr,
  output logic                                               fill_ack,
  output logic [DDR_DATA_WIDTH-1:0]                          fill_data,
  output logic                                               fill_valid,
  output logic [((LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1)-1:0] fill_idx,
  output logic                                               fill_done,
  input  logic                                               wbuf_we,
  input  logic [((LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1)-1:0] wbuf_idx,
  input  logic [DDR_DATA_WIDTH-1:0]                          wbuf_data,
  input  logic                                               evict_req,
  input  logic [DDR_ADDR_WIDTH-1:0]                          evict_addr,
  output logic                                               evict_ack,
  output logic                                               evict_done,
  output logic                                               busy,
  output logic                                               err_timeout,
  output logic                                               rd_burst_req,
  output logic [9:0]                                         rd_burst_len,
  output logic [DDR_ADDR_WIDTH-1:0]                          rd_burst_addr,
  input  logic                                               rd_burst_data_valid,
  input  logic [DDR_DATA_WIDTH-1:0]                          rd_burst_data,
  input  logic                                               rd_burst_finish,
  output logic                                               wr_burst_req,
  output logic [9:0]                                         wr_burst_len,
  output logic [DDR_ADDR_WIDTH-1:0]                          wr_burst_addr,
  input  logic                                               wr_burst_data_req,
  output logic [DDR_DATA_WIDTH-1:0]                          wr_burst_data,
  input  logic                                               wr_burst_finish
);

  localparam int unsigned DW = DDR_DATA_WIDTH;
  localparam int unsigned IW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_DATA, WR_ISSUE, WR_DATA, FINISH
  } state_t;

  state_t          state_q, state_d;
  logic            grant_rd, grant_wr;
  logic            last_wr;
  logic            wbuf_lock;
  logic            in_data, wd_expire;
  logic [IW-1:0]   rd_beat, wr_beat;
  logic [WW-1:0]   wd_cnt;
  logic [DW-1:0]   wbuf [LINE_BEATS];

  assign rd_burst_len = 10'(LINE_BEATS);
  assign wr_burst_len = 10'(LINE_BEATS);
  assign in_data      = (state_q == RD_DATA) || (state_q == WR_DATA);
  assign wd_expire    = (wd_cnt == WW'(TIMEOUT - 1));

  // Next-state and grant decode; round-robin only matters on a collision
  always_comb begin
    state_d  = state_q;
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (init_calib_complete) begin
          if (fill_req && evict_req) begin
            grant_rd = last_wr;
            grant_wr = !last_wr;
          end else begin
            grant_rd = fill_req;
            grant_wr = evict_req;
          end
          if (grant_rd)      state_d = RD_ISSUE;
          else if (grant_wr) state_d = WR_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_DATA;
      WR_ISSUE: state_d = WR_DATA;
      RD_DATA:  if (rd_burst_finish || wd_expire) state_d = FINISH;
      WR_DATA:  if (wr_burst_finish || wd_expire) state_d = FINISH;
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_wr       <= 1'b1;
      wbuf_lock     <= 1'b0;
      rd_beat       <= '0;
      wr_beat       <= '0;
      wd_cnt        <= '0;
      fill_ack      <= 1'b0;
      evict_ack     <= 1'b0;
      fill_data     <= '0;
      fill_valid    <= 1'b0;
      fill_idx      <= '0;
      fill_done     <= 1'b0;
      evict_done    <= 1'b0;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
      rd_burst_req  <= 1'b0;
      rd_burst_addr <= '0;
      wr_burst_req  <= 1'b0;
      wr_burst_addr <= '0;
      wr_burst_data <= '0;
    end else begin
      state_q      <= state_d;
      busy         <= (state_d != IDLE);
      fill_ack     <= grant_rd;
      evict_ack    <= grant_wr;
      rd_burst_req <= (state_q == RD_ISSUE);
      wr_burst_req <= (state_q == WR_ISSUE);
      fill_done    <= (state_q == RD_DATA) && (state_d == FINISH);
      evict_done   <= (state_q == WR_DATA) && (state_d == FINISH);
      fill_valid   <= 1'b0;

      if (grant_rd) rd_burst_addr <= fill_addr;
      if (grant_wr) wr_burst_addr <= evict_addr;
      if (grant_rd || grant_wr) last_wr <= grant_wr;

      // Buffer stays locked from the evict grant until the write burst ends
      if (grant_wr) wbuf_lock <= 1'b1;
      else if ((state_q == WR_DATA) && (state_d == FINISH)) wbuf_lock <= 1'b0;

      if ((state_q == RD_DATA) && rd_burst_data_valid) begin
        fill_data  <= rd_burst_data;
        fill_valid <= 1'b1;
        fill_idx   <= rd_beat;
        rd_beat    <= (rd_beat == IW'(LINE_BEATS - 1)) ? '0 : rd_beat + IW'(1);
      end

      // Registered read lines data up with the controller's registered wren
      if ((state_q == WR_DATA) && wr_burst_data_req) begin
        wr_burst_data <= wbuf[wr_beat];
        wr_beat       <= (wr_beat == IW'(LINE_BEATS - 1)) ? '0 : wr_beat + IW'(1);
      end

      if (in_data) begin
        wd_cnt <= wd_cnt + WW'(1);
        if (wd_expire) err_timeout <= 1'b1;
      end

      if (state_q == FINISH) begin
        rd_beat <= '0;
        wr_beat <= '0;
        wd_cnt  <= '0;
      end
    end
  end

  // Line buffer: contents survive reset
  always_ff @(posedge clk) begin
    if (wbuf_we && !wbuf_lock) wbuf[wbuf_idx] <= wbuf_data;
  end

endmodule
